alu_4bit: RTL and testbench
===========================

Name: alu_4bit

Overview:
- 4-bit, four-function ALU (add, subtract, multiply, compare) with an 8-bit registered result.
- Used as the arithmetic unit of the vending-machine datapath, for example for price/credit computation and the "credit >= price" check.
- Single clock domain, synchronous active-high reset, one-cycle latency.

Parameters:
- None. Operand width is fixed at 4 bits and result width at 8 bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- a  input  4  operand A, unsigned
- b  input  4  operand B, unsigned
- s0  input  1  operation select, bit 0
- s1  input  1  operation select, bit 1
- alu_en  input  1  ALU enable; when low, result is forced to zero
- result  output  8  registered operation result, unsigned
- result_valid  output  1  registered; high when result holds an enabled operation's output

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
  - On a rising clk edge with reset=1: result <= 8'h00 and result_valid <= 0.
  - reset has priority over all other inputs.
- Latency:
  - Inputs are sampled on each rising edge.
  - result and result_valid reflect the inputs sampled at the previous edge (1-cycle latency).
  - Fully pipelined: a new operation can be issued every cycle.
- Operation select {s1,s0}; operands are zero-extended to 8 bits before each operation:
  - 00 add: result = a + b. Maximum 15+15 = 30, so there is no overflow.
  - 01 subtract: result = (a - b) mod 256, in 8-bit two's complement.
    - If a < b the result wraps, e.g. 3-6 = 8'hFD.
    - There is no borrow or flag output.
  - 10 multiply: result = a * b, unsigned. Maximum 15*15 = 225 = 8'hE1, which fits in 8 bits.
  - 11 compare: result = 8'h01 if a >= b, else 8'h00. Equality gives 8'h01.
- Enable:
  - alu_en=0 at a sampled edge: result <= 8'h00 and result_valid <= 0, regardless of a, b, s0, s1.
  - alu_en=1: result_valid <= 1.
- Output stability: result is held stable between edges; there is no combinational path from inputs to outputs.
- Reset mid-operation: the in-flight result is discarded. The first valid result appears one cycle after reset deasserts with alu_en=1.
- Unknown input handling: none required. Inputs are assumed driven with known values whenever alu_en=1.

Test Plan:
- Reset:
  - Assert reset for 2 cycles with alu_en=1, a=9, b=5 -> result=8'h00 and result_valid=0 during reset.
  - Deassert reset -> the next edge gives result=14.
- Add and subtract:
  - Add: alu_en=1, {s1,s0}=00, a=9, b=5 -> one cycle later result=8'h0E (14), result_valid=1.
  - Subtract: {s1,s0}=01, a=6, b=3 -> 8'h03.
  - Subtract with wrap: a=3, b=6 -> 8'hFD.
  - Subtract to zero: a=0, b=0 -> 8'h00.
- Multiply:
  - {s1,s0}=10, a=3, b=3 -> 8'h09.
  - a=15, b=15 -> 8'hE1 (225).
  - a=0, b=15 -> 8'h00.
- Compare, {s1,s0}=11:
  - a=5, b=6 -> 8'h00.
  - a=6, b=3 -> 8'h01.
  - a=7, b=7 -> 8'h01.
- Disable:
  - alu_en=0, a=15, b=1, {s1,s0}=00 -> next edge result=8'h00, result_valid=0.
  - Re-enable with the same inputs -> 8'h10 (16).
- Back-to-back throughput: change op and operands every cycle through all four ops -> each result appears exactly one cycle after its inputs, with no bubbles.
- Exhaustive sweep: all 256 (a,b) pairs × 4 ops, each compared against a reference model.

Source files
------------

// File: rtl/alu_4bit.sv
// -----------------------------------------------------------------------------
// alu_4bit
//   Four-function 4-bit ALU with an 8-bit registered result. Used by the
//   vending-machine datapath for price/credit arithmetic and for the
//   "credit >= price" decision.
//
//   Operations, selected by {s1,s0}; operands are zero-extended to 8 bits:
//     00  add       result = a + b             (max 30, never overflows)
//     01  subtract  result = (a - b) mod 256   (wraps when a < b)
//     10  multiply  result = a * b             (max 225, fits in 8 bits)
//     11  compare   result = 8'h01 if a >= b, else 8'h00
//
// Ports:
//   clk           in   1  system clock, rising edge
//   reset         in   1  synchronous, active-high; highest priority
//   a, b          in   4  unsigned operands
//   s0, s1        in   1  operation select bits
//   alu_en        in   1  enable; when low the registered result is zero
//   result        out  8  registered result
//   result_valid  out  1  registered qualifier for result
//
// Valid semantics: result_valid is high for exactly the cycle in which
// result carries the output of an operation issued with alu_en=1 at the
// previous rising edge. There is no ready/backpressure: the consumer must
// take the value in that cycle. A new operation may be issued every cycle.
// -----------------------------------------------------------------------------
module alu_4bit (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       s0,
  input  logic       s1,
  input  logic       alu_en,
  output logic [7:0] result,
  output logic       result_valid
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_CMP = 2'b11
  } alu_op_e;

  alu_op_e    op;
  logic [7:0] a_ext;
  logic [7:0] b_ext;
  logic [7:0] op_result;

  assign op    = alu_op_e'({s1, s0});
  assign a_ext = {4'h0, a};
  assign b_ext = {4'h0, b};

  always_comb begin
    op_result = 8'h00;
    unique case (op)
      OP_ADD: op_result = a_ext + b_ext;
      // 8-bit subtraction gives the two's-complement wrap directly.
      OP_SUB: op_result = a_ext - b_ext;
      OP_MUL: op_result = a_ext * b_ext;
      OP_CMP: op_result = (a >= b) ? 8'h01 : 8'h00;
      default: op_result = 8'h00;
    endcase
  end

  // Only registered values reach the outputs, so there is no
  // combinational path from any input to result/result_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      result       <= 8'h00;
      result_valid <= 1'b0;
    end else if (!alu_en) begin
      result       <= 8'h00;
      result_valid <= 1'b0;
    end else begin
      result       <= op_result;
      result_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_4bit.sv
module tb_alu_4bit;

  // ---------------------------------------------------------------------------
  // Clock and DUT
  // ---------------------------------------------------------------------------
  logic       clk;
  logic       reset;
  logic [3:0] a;
  logic [3:0] b;
  logic       s0;
  logic       s1;
  logic       alu_en;
  logic [7:0] result;
  logic       result_valid;

  alu_4bit dut (
    .clk          (clk),
    .reset        (reset),
    .a            (a),
    .b            (b),
    .s0           (s0),
    .s1           (s1),
    .alu_en       (alu_en),
    .result       (result),
    .result_valid (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Scoreboard: {result_valid, result}
  // ---------------------------------------------------------------------------
  logic [8:0] exp_q[$];
  logic [8:0] last_exp;
  int         checks;
  int         failures;

  // Reference model written from the operation table with integer math.
  function automatic logic [8:0] model(input logic rst, input logic en,
                                       input logic [1:0] op,
                                       input logic [3:0] av,
                                       input logic [3:0] bv);
    int ai;
    int bi;
    int r;
    ai = int'(av);
    bi = int'(bv);
    r  = 0;
    if (rst || !en) return 9'h000;
    case (op)
      2'b00: r = ai + bi;
      2'b01: r = (ai - bi + 256) % 256;
      2'b10: r = ai * bi;
      default: r = (ai >= bi) ? 1 : 0;
    endcase
    return {1'b1, 8'(r)};
  endfunction

  task automatic check(input string tag, input logic [8:0] got,
                       input logic [8:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got valid=%b result=%h, expected valid=%b result=%h",
             tag, got[8], got[7:0], exp[8], exp[7:0]);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: apply one operation at the falling edge, confirm the outputs did
  // not react combinationally, then compare after the next rising edge.
  // ---------------------------------------------------------------------------
  task automatic step(input logic rst, input logic en, input logic [1:0] op,
                      input logic [3:0] av, input logic [3:0] bv,
                      input string tag);
    logic [8:0] exp;
    @(negedge clk);
    reset  = rst;
    alu_en = en;
    {s1, s0} = op;
    a = av;
    b = bv;
    #1;
    check({tag, "_hold"}, {result_valid, result}, last_exp);
    exp_q.push_back(model(rst, en, op, av, bv));
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check(tag, {result_valid, result}, exp);
    last_exp = exp;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    alu_en   = 1'b1;
    a        = 4'd9;
    b        = 4'd5;
    s0       = 1'b0;
    s1       = 1'b0;
    last_exp = 9'h000;

    // Reset with live operands, then release.
    step(1'b1, 1'b1, 2'b00, 4'd9, 4'd5, "reset_1");
    step(1'b1, 1'b1, 2'b00, 4'd9, 4'd5, "reset_2");
    step(1'b0, 1'b1, 2'b00, 4'd9, 4'd5, "add_9_5");

    // Subtract
    step(1'b0, 1'b1, 2'b01, 4'd6, 4'd3, "sub_6_3");
    step(1'b0, 1'b1, 2'b01, 4'd3, 4'd6, "sub_wrap_3_6");
    step(1'b0, 1'b1, 2'b01, 4'd0, 4'd0, "sub_0_0");

    // Multiply
    step(1'b0, 1'b1, 2'b10, 4'd3, 4'd3, "mul_3_3");
    step(1'b0, 1'b1, 2'b10, 4'd15, 4'd15, "mul_15_15");
    step(1'b0, 1'b1, 2'b10, 4'd0, 4'd15, "mul_0_15");

    // Compare
    step(1'b0, 1'b1, 2'b11, 4'd5, 4'd6, "cmp_5_6");
    step(1'b0, 1'b1, 2'b11, 4'd6, 4'd3, "cmp_6_3");
    step(1'b0, 1'b1, 2'b11, 4'd7, 4'd7, "cmp_7_7");

    // Disable and re-enable
    step(1'b0, 1'b0, 2'b00, 4'd15, 4'd1, "disable");
    step(1'b0, 1'b1, 2'b00, 4'd15, 4'd1, "reenable");

    // Reset in the middle of a stream discards the in-flight result.
    step(1'b0, 1'b1, 2'b10, 4'd15, 4'd15, "pre_reset_mul");
    step(1'b1, 1'b1, 2'b10, 4'd15, 4'd15, "mid_reset");
    step(1'b0, 1'b1, 2'b01, 4'd3, 4'd6, "post_reset_sub");

    // Back-to-back random traffic across all ops, including disabled slots.
    for (int i = 0; i < 64; i++) begin
      step(1'b0, ($urandom_range(0, 7) != 0),
           2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), "random");
    end

    // Exhaustive sweep: every (a,b) pair for every op.
    for (int op = 0; op < 4; op++) begin
      for (int ai = 0; ai < 16; ai++) begin
        for (int bi = 0; bi < 16; bi++) begin
          step(1'b0, 1'b1, 2'(op), 4'(ai), 4'(bi), "sweep");
        end
      end
    end

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL queue_drain: got %0d leftover entries, expected 0",
             exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
